// File: rtl/core6_oci_trace_pkg.sv
// Shared constants and types for the Core6 OCI DCT trace packer.
package core6_oci_trace_pkg;

  localparam int DCT_SLOTS = 15;
  localparam int CNT_W     = 4;
  localparam int BUF_W     = 2 * DCT_SLOTS;
  localparam int FRAME_W   = 2 + CNT_W + BUF_W;

  localparam logic [1:0] DCT_NT  = 2'b01;
  localparam logic [1:0] DCT_TK  = 2'b10;
  localparam logic [1:0] DCT_IND = 2'b11;

  localparam logic [1:0] FRM_FULL  = 2'b01;
  localparam logic [1:0] FRM_FLUSH = 2'b10;

  localparam int FRM_BUF_LSB  = 0;
  localparam int FRM_CNT_LSB  = BUF_W;
  localparam int FRM_TYPE_LSB = BUF_W + CNT_W;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } dct_state_t;

endpackage

// File: rtl/core6_cpu_1_oci_dct_packer_if.sv
// Valid/ready trace-frame channel from the DCT packer to the trace FIFO.
interface core6_cpu_1_oci_dct_packer_if #(
  parameter int FRAME_W = core6_oci_trace_pkg::FRAME_W
);
  logic               frame_valid;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_data;

  modport master (output frame_valid, output frame_data, input frame_ready);
  modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/core6_oci_frame_reg.sv
// One-entry valid/ready holding register; data only changes when the slot is free.
module core6_oci_frame_reg #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/core6_cpu_1_oci_dct_packer.sv
// Packs 2-bit DCT outcome codes into slot buffers and launches full/flush trace frames.
// Build option CORE6_DCT_DROP_CNT_EN adds a saturating drop_cnt output.
//
// state   | meaning
// --------+-------------------------------------------
// ST_FILL | accepting codes, count 0..DCT_SLOTS-1
// ST_FULL | count == DCT_SLOTS, waiting for frame slot
module core6_cpu_1_oci_dct_packer
  import core6_oci_trace_pkg::*;
#(
  parameter int DCT_SLOTS = core6_oci_trace_pkg::DCT_SLOTS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              trace_en,
  input  logic                              dct_valid,
  input  logic [1:0]                        dct_code,
  input  logic                              flush,
  core6_cpu_1_oci_dct_packer_if.master      frame,
  output logic [2*DCT_SLOTS-1:0]            dct_buffer,
  output logic [$clog2(DCT_SLOTS+1)-1:0]    dct_count,
  output logic                              overflow
`ifdef CORE6_DCT_DROP_CNT_EN
  ,
  output logic [7:0]                        drop_cnt
`endif
);

  localparam int BUF_BITS   = 2 * DCT_SLOTS;
  localparam int CNT_BITS   = $clog2(DCT_SLOTS + 1);
  localparam int FRAME_BITS = 2 + CNT_BITS + BUF_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DCT_SLOTS);

  dct_state_t            state;
  logic                  flush_pend;
  logic                  slot_free;
  logic                  legal;
  logic                  stalled;
  logic                  accept;
  logic                  drop;
  logic                  launch_full;
  logic                  launch_flush;
  logic                  launch;
  logic [1:0]            frm_type;
  logic [FRAME_BITS-1:0] frame_n;
  logic [BUF_BITS-1:0]   buf_n;
  logic [CNT_BITS-1:0]   cnt_n;

  assign legal        = trace_en && dct_valid && (dct_code != 2'b00);
  assign stalled      = (state == ST_FULL) && !slot_free;
  assign accept       = legal && !stalled;
  assign drop         = legal && stalled;
  assign launch_full  = (state == ST_FULL) && slot_free;
  assign launch_flush = flush_pend && (dct_count != '0) && slot_free;
  assign launch       = launch_full || launch_flush;
  assign frm_type     = launch_full ? FRM_FULL : FRM_FLUSH;
  assign frame_n      = {frm_type, dct_count, dct_buffer};

  // A launch empties the buffer first, so a same-cycle code lands in slot 0.
  always_comb begin
    buf_n = launch ? '0 : dct_buffer;
    cnt_n = launch ? '0 : dct_count;
    if (accept) begin
      for (int k = 0; k < DCT_SLOTS; k++) begin
        if (cnt_n == CNT_BITS'(k)) buf_n[2*k +: 2] = dct_code;
      end
      cnt_n = cnt_n + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
    end else begin
      dct_buffer <= buf_n;
      dct_count  <= cnt_n;
      // A flush that would leave nothing to emit is dropped immediately.
      flush_pend <= (flush || (flush_pend && !launch)) && (cnt_n != '0);
      case (state)
        ST_FILL: if (cnt_n == CNT_MAX) state <= ST_FULL;
        ST_FULL: if (launch) state <= (cnt_n == CNT_MAX) ? ST_FULL : ST_FILL;
        default: state <= ST_FILL;
      endcase
    end
  end

  core6_oci_frame_reg #(.W(FRAME_BITS)) u_frame_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (launch),
    .load_data (frame_n),
    .ready     (frame.frame_ready),
    .valid     (frame.frame_valid),
    .data      (frame.frame_data),
    .free      (slot_free)
  );

`ifdef CORE6_DCT_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt <= 8'd0;
    else if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end

  assign overflow = (drop_cnt != 8'd0);
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`endif

endmodule
